// File: rtl/angle_update_ctrl_if.sv
// Bus bundle between the angle update controller and its environment:
// UART RX FIFO read side, video frame sync and the applied-angle outputs.
interface angle_update_ctrl_if;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        frame_sync;
  logic [15:0] angle_out;
  logic        angle_valid;
  logic        angle_stale;
  logic [7:0]  frame_err_cnt;

  // Environment side: supplies FIFO bytes and frame sync, observes the angle.
  modport master (
    output fifo_data, fifo_empty, frame_sync,
    input  fifo_rd_en, angle_out, angle_valid, angle_stale, frame_err_cnt
  );

  // Controller side.
  modport slave (
    input  fifo_data, fifo_empty, frame_sync,
    output fifo_rd_en, angle_out, angle_valid, angle_stale, frame_err_cnt
  );
endinterface

// File: rtl/angle_update_ctrl.sv
// Angle update controller: drains 4-byte angle frames (hi, lo, CR, LF) from a
// UART RX FIFO, validates them, and applies the latest good angle to the
// rotation datapath on the falling edge of the video frame sync. Tracks
// rejected frames and flags a stale angle when good frames stop arriving.
module angle_update_ctrl #(
  parameter logic [15:0] ANGLE_MAX      = 16'd359,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  angle_update_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_HI   = 3'd0,
    S_LO   = 3'd1,
    S_CR   = 3'd2,
    S_LF   = 3'd3,
    S_SYNC = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        rd_en_r;
  logic        byte_vld_r;
  logic [7:0]  hi_r;
  logic [7:0]  lo_r;
  logic        load_hi_s;
  logic        load_lo_s;
  logic        good_s;
  logic        err_s;
  logic        pend_r;
  logic [15:0] pend_angle_r;
  logic        fs_d0_r;
  logic        fall_s;
  logic [15:0] angle_out_r;
  logic        angle_valid_r;
  logic [7:0]  err_cnt_r;
  logic [31:0] to_cnt_r;
  logic [31:0] to_cnt_nxt_s;
  logic        stale_r;

  assign fall_s = fs_d0_r & ~bus.frame_sync;

  // Read strobe alternates so at most one read per two cycles; the byte is
  // valid on the FIFO output the cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_r    <= 1'b0;
      byte_vld_r <= 1'b0;
    end else begin
      rd_en_r    <= ~bus.fifo_empty & ~rd_en_r;
      byte_vld_r <= rd_en_r;
    end
  end

  // Parser next-state and frame decode; advances only on a received byte.
  always_comb begin
    state_nxt_s = state_r;
    load_hi_s   = 1'b0;
    load_lo_s   = 1'b0;
    good_s      = 1'b0;
    err_s       = 1'b0;
    if (byte_vld_r) begin
      case (state_r)
        S_HI: begin
          load_hi_s   = 1'b1;
          state_nxt_s = S_LO;
        end
        S_LO: begin
          load_lo_s   = 1'b1;
          state_nxt_s = S_CR;
        end
        S_CR: begin
          if (bus.fifo_data == 8'h0D) begin
            state_nxt_s = S_LF;
          end else begin
            err_s       = 1'b1;
            state_nxt_s = S_SYNC;
          end
        end
        S_LF: begin
          if (bus.fifo_data == 8'h0A) begin
            state_nxt_s = S_HI;
            if ({hi_r, lo_r} <= ANGLE_MAX) begin
              good_s = 1'b1;
            end else begin
              err_s = 1'b1;
            end
          end else begin
            err_s       = 1'b1;
            state_nxt_s = S_SYNC;
          end
        end
        S_SYNC: begin
          if (bus.fifo_data == 8'h0A) begin
            state_nxt_s = S_HI;
          end else begin
            state_nxt_s = S_SYNC;
          end
        end
        default: begin
          state_nxt_s = S_HI;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Parser state register and captured angle bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_HI;
      hi_r    <= 8'd0;
      lo_r    <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (load_hi_s) begin
        hi_r <= bus.fifo_data;
      end
      if (load_lo_s) begin
        lo_r <= bus.fifo_data;
      end
    end
  end

  // Pending angle: newest good frame wins; a sync edge consumes the pending
  // value unless a new good frame lands in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r       <= 1'b0;
      pend_angle_r <= 16'd0;
    end else if (good_s) begin
      pend_r       <= 1'b1;
      pend_angle_r <= {hi_r, lo_r};
    end else if (fall_s) begin
      pend_r <= 1'b0;
    end
  end

  // Frame sync history and angle application on its falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_d0_r       <= 1'b0;
      angle_out_r   <= 16'd0;
      angle_valid_r <= 1'b0;
    end else begin
      fs_d0_r <= bus.frame_sync;
      if (fall_s && pend_r) begin
        angle_out_r   <= pend_angle_r;
        angle_valid_r <= 1'b1;
      end else begin
        angle_valid_r <= 1'b0;
      end
    end
  end

  // Rejected frame counter, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (err_s && (err_cnt_r != 8'd255)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  // Cycles since last good frame, saturating at the timeout.
  always_comb begin
    to_cnt_nxt_s = to_cnt_r;
    if (good_s) begin
      to_cnt_nxt_s = 32'd0;
    end else if (to_cnt_r != TIMEOUT_CYCLES) begin
      to_cnt_nxt_s = to_cnt_r + 32'd1;
    end else begin
      to_cnt_nxt_s = to_cnt_r;
    end
  end

  // Timeout counter and stale flag kept in lockstep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= TIMEOUT_CYCLES;
      stale_r  <= 1'b1;
    end else begin
      to_cnt_r <= to_cnt_nxt_s;
      stale_r  <= (to_cnt_nxt_s == TIMEOUT_CYCLES);
    end
  end

  assign bus.fifo_rd_en    = rd_en_r;
  assign bus.angle_out     = angle_out_r;
  assign bus.angle_valid   = angle_valid_r;
  assign bus.angle_stale   = stale_r;
  assign bus.frame_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_angle_update_ctrl.sv
// Self-checking bench for angle_update_ctrl: table of frame vectors plus
// hand-written sequences for edge/frame coincidence, timeout, saturation and
// mid-frame reset. Applied angles are checked through a scoreboard queue.
module tb_angle_update_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  angle_update_ctrl_if bus ();

  angle_update_ctrl #(
    .ANGLE_MAX      (16'd359),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [71:0] bytes;
    int          n;
    logic [15:0] exp_angle;
    logic        exp_pulse;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t        vecs [6];
  logic [7:0]  fifo_q [$];
  logic [15:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pulses  = 0;
  logic        prev_rd = 1'b0;
  logic        last_pop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then service the FIFO.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (bus.angle_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got angle %0d expected no pulse", bus.angle_out);
      end else begin
        e = exp_q.pop_front();
        check("valid_angle", {16'd0, bus.angle_out}, {16'd0, e});
      end
    end
    if (bus.fifo_rd_en) begin
      check("rd_gap", {31'd0, prev_rd}, 32'd0);
      if (fifo_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_underflow: got read strobe expected none on empty FIFO");
      end else begin
        bus.fifo_data = fifo_q.pop_front();
        if (fifo_q.size() == 0) last_pop = 1'b1;
      end
    end
    prev_rd = bus.fifo_rd_en;
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    tick();
    while ((fifo_q.size() != 0 || bus.fifo_rd_en) && g < 5000) begin
      tick();
      g++;
    end
    if (g >= 5000) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got %0d bytes left expected 0", fifo_q.size());
    end
    repeat (4) tick();
  endtask

  task automatic wait_last_pop();
    int g;
    g = 0;
    while (!last_pop && g < 500) begin
      tick();
      g++;
    end
    if (!last_pop) begin
      n_tests++;
      n_fail++;
      $display("FAIL last_pop_timeout: got no final read expected one");
    end
  endtask

  task automatic push_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] cr, input logic [7:0] lf);
    fifo_q.push_back(hi);
    fifo_q.push_back(lo);
    fifo_q.push_back(cr);
    fifo_q.push_back(lf);
    last_pop = 1'b0;
  endtask

  task automatic do_sync();
    pulses = 0;
    bus.frame_sync = 1'b1;
    repeat (2) tick();
    bus.frame_sync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [71:0] bb;
    vecs[0] = '{1'b0, 72'h005A0D0A_0000000000, 4, 16'd90,  1'b1, 8'd0};
    vecs[1] = '{1'b0, 72'h01680D0A_0000000000, 4, 16'd90,  1'b0, 8'd1};
    vecs[2] = '{1'b1, 72'h00100E330A002D0D0A,  9, 16'd45,  1'b1, 8'd1};
    vecs[3] = '{1'b0, 72'h000A0D0A_00140D0A_00, 8, 16'd20, 1'b1, 8'd1};
    vecs[4] = '{1'b0, 72'h0,                   0, 16'd20,  1'b0, 8'd1};
    vecs[5] = '{1'b0, 72'h00010D0D0A01670D0A,  9, 16'd359, 1'b1, 8'd2};

    rst_n          = 1'b0;
    bus.fifo_data  = 8'd0;
    bus.fifo_empty = 1'b1;
    bus.frame_sync = 1'b0;
    repeat (2) tick();
    check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("rst_angle", {16'd0, bus.angle_out}, 32'd0);
    check("rst_valid", {31'd0, bus.angle_valid}, 32'd0);
    check("rst_err", {24'd0, bus.frame_err_cnt}, 32'd0);
    check("rst_stale", {31'd0, bus.angle_stale}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Table-driven frames, applied with one sync edge each.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst_first) do_reset();
      bb = vecs[i].bytes;
      for (int j = 0; j < vecs[i].n; j++) fifo_q.push_back(bb[71-8*j -: 8]);
      wait_idle();
      if (vecs[i].exp_pulse) exp_q.push_back(vecs[i].exp_angle);
      do_sync();
      check($sformatf("v%0d_angle", i), {16'd0, bus.angle_out}, {16'd0, vecs[i].exp_angle});
      check($sformatf("v%0d_pulses", i), pulses, {31'd0, vecs[i].exp_pulse});
      check($sformatf("v%0d_err", i), {24'd0, bus.frame_err_cnt}, {24'd0, vecs[i].exp_err});
      check($sformatf("v%0d_stale", i), {31'd0, bus.angle_stale}, 32'd0);
      check($sformatf("v%0d_sb", i), exp_q.size(), 32'd0);
    end

    // Good frame completing in the same cycle as the sync falling edge.
    do_reset();
    push_frame(8'h00, 8'h0A, 8'h0D, 8'h0A);
    wait_idle();
    bus.frame_sync = 1'b1;
    repeat (2) tick();
    push_frame(8'h00, 8'h1E, 8'h0D, 8'h0A);
    wait_last_pop();
    exp_q.push_back(16'd10);
    pulses = 0;
    tick();
    bus.frame_sync = 1'b0;
    repeat (4) tick();
    check("coin_angle", {16'd0, bus.angle_out}, 32'd10);
    check("coin_pulses", pulses, 32'd1);
    exp_q.push_back(16'd30);
    do_sync();
    check("coin_next_angle", {16'd0, bus.angle_out}, 32'd30);
    check("coin_next_pulses", pulses, 32'd1);

    // Timeout: stale after 100 idle cycles, cleared by the next good frame.
    do_reset();
    check("to_rst_stale", {31'd0, bus.angle_stale}, 32'd1);
    push_frame(8'h00, 8'h05, 8'h0D, 8'h0A);
    wait_last_pop();
    repeat (3) tick();
    check("to_fresh", {31'd0, bus.angle_stale}, 32'd0);
    repeat (90) tick();
    check("to_before", {31'd0, bus.angle_stale}, 32'd0);
    repeat (15) tick();
    check("to_after", {31'd0, bus.angle_stale}, 32'd1);
    push_frame(8'h00, 8'h06, 8'h0D, 8'h0A);
    wait_idle();
    check("to_recover", {31'd0, bus.angle_stale}, 32'd0);

    // Error saturation, then reset in the middle of a frame.
    do_reset();
    push_frame(8'h00, 8'h07, 8'h0D, 8'h0A);
    wait_idle();
    exp_q.push_back(16'd7);
    do_sync();
    check("sat_pre_angle", {16'd0, bus.angle_out}, 32'd7);
    for (int k = 0; k < 100; k++) push_frame(8'h00, 8'h00, 8'h0E, 8'h0A);
    wait_idle();
    check("sat_100", {24'd0, bus.frame_err_cnt}, 32'd100);
    for (int k = 0; k < 200; k++) push_frame(8'h00, 8'h00, 8'h0E, 8'h0A);
    wait_idle();
    check("sat_255", {24'd0, bus.frame_err_cnt}, 32'd255);
    push_frame(8'h00, 8'h21, 8'h0D, 8'h0A);
    fifo_q.push_back(8'h00);
    wait_idle();
    check("sat_hold", {24'd0, bus.frame_err_cnt}, 32'd255);
    rst_n = 1'b0;
    tick();
    check("mid_rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("mid_rst_angle", {16'd0, bus.angle_out}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.angle_valid}, 32'd0);
    check("mid_rst_err", {24'd0, bus.frame_err_cnt}, 32'd0);
    check("mid_rst_stale", {31'd0, bus.angle_stale}, 32'd1);
    rst_n = 1'b1;
    tick();
    do_sync();
    check("post_rst_no_pend", pulses, 32'd0);
    push_frame(8'h00, 8'h0C, 8'h0D, 8'h0A);
    wait_idle();
    exp_q.push_back(16'd12);
    do_sync();
    check("post_rst_angle", {16'd0, bus.angle_out}, 32'd12);
    check("post_rst_err", {24'd0, bus.frame_err_cnt}, 32'd0);
    check("post_rst_sb", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
